serial_tx_param: RTL

SERIAL_TX_PARAM -- requirements
Module: serial_tx_param

---
 rtl/serial_tx_param.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_tx_param.sv
// serial_tx_param: parameterised UART-style serial transmitter.
// Frame: start(0), DATA_W payload bits LSB first, optional parity, STOP_BITS stop bits (1).
// Latency: start bit on line the cycle after acceptance; done/ready pulse F cycles later.
// Backpressure: accepts start only while ready=1; start while busy is dropped, never queued.
// Ports:
//   clk, rstn (sync, active-low)   start, data_in[DATA_W]  -> request side
//   ready, busy, done, serial_out  -> all registered outputs
module serial_tx_param #(
  parameter int DATA_W       = 7,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              serial_out
);

  // A 1-cycle bit still needs a 1-bit counter, which simply stays at 0.
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W);

  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_MAX = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_MAX = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] data_q;
  logic              parity_q;
  logic              so_d, done_d, ready_d;
  logic              accept, baud_last;

  assign accept    = (state_q == S_IDLE) && start;
  assign baud_last = (baud_q == BAUD_MAX);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      parity_q   <= 1'b0;
      serial_out <= 1'b1;
      done       <= 1'b0;
      ready      <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      serial_out <= so_d;
      done       <= done_d;
      ready      <= ready_d;
      busy       <= !ready_d;
      if (accept) begin
        data_q   <= data_in;
        parity_q <= (PARITY_MODE == 2) ? ~(^data_in) : (^data_in);
      end
    end
  end

  // Next state and counters.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_START;
      S_START:  if (baud_last) state_d = S_DATA;
      S_DATA:   if (baud_last && bit_q == DATA_MAX)
                  state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (baud_last) state_d = S_STOP;
      S_STOP:   if (baud_last && bit_q == STOP_MAX) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Baud counter reloads at every bit boundary and is parked at 0 in idle.
    if (state_q == S_IDLE || baud_last)
      baud_d = '0;
    else
      baud_d = baud_q + 1'b1;

    // Bit index restarts on every state change, so it serves both the
    // payload bits and the stop bits without ever wrapping.
    if (state_d != state_q)
      bit_d = '0;
    else if (baud_last && (state_q == S_DATA || state_q == S_STOP))
      bit_d = bit_q + 1'b1;
    else
      bit_d = bit_q;
  end

  // Outputs are decoded from the next state so the registered line
  // changes on the same edge as the state.
  always_comb begin
    so_d = 1'b1;
    case (state_d)
      S_START:  so_d = 1'b0;
      S_DATA:   so_d = data_q[bit_d];
      S_PARITY: so_d = parity_q;
      default:  so_d = 1'b1;
    endcase
    done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

endmodule
